dbus_sram_responder: RTL

//  Responder end of the CPU data bus: accepts dbus_req_t from the load/store

---
 rtl/dbus_sram_responder.sv | 119 +++++++++++
 1 files changed

// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: responder end of the CPU data bus, backed by an on-chip word SRAM.
// Accepts one request at a time and returns the pre-write word LATENCY cycles later.
//   clk    in   clock, all state on rising edge
//   reset  in   synchronous active-high reset
//   dreq   in   dbus_req_t  {valid, addr[31:0], size[2:0], strobe[3:0], data[31:0]}
//   dresp  out  dbus_resp_t {addr_ok, data_ok, data[31:0]}
//   busy   out  high while a request is in flight (WAIT state)

package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
endpackage

module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       busy
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] hold_q, hold_d;
    logic        accept;
    logic        data_ok;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;

    // Upper address bits alias onto the array; byte offset and size are not checked.
    assign idx = dreq.addr[AW+1:2];

    logic unused_dreq;
    assign unused_dreq = ^{dreq.addr[31:AW+2], dreq.addr[1:0], dreq.size};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        hold_d  = hold_q;
        accept  = 1'b0;
        data_ok = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dreq.valid && !reset) begin
                    accept  = 1'b1;
                    rdata_d = mem[idx];  // pre-write word
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                busy = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Reset in this cycle drops the pending response.
                    data_ok = !reset;
                    hold_d  = rdata_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign dresp.addr_ok = accept;
    assign dresp.data_ok = data_ok;
    // Data holds its last delivered value between responses.
    assign dresp.data    = data_ok ? rdata_q : hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            hold_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            hold_q  <= hold_d;
        end
    end

    // SRAM contents survive reset; writes commit at acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (dreq.strobe[i]) begin
                    mem[idx][8*i +: 8] <= dreq.data[8*i +: 8];
                end
            end
        end
    end

endmodule
